// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the register-bus transfer arbiter.
// Holds the sequencer state encoding, default sizes and the index-to-one-hot
// decode used for the register output-enable and load vectors.
package reg_bus_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int NREG_DEFAULT = 8;

    // Widest register bank the decode helper supports.
    localparam int NREG_MAX = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Index to one-hot. An index past the bank width shifts the bit out,
    // so callers that keep only the low NREG bits see an all-zero vector.
    function automatic logic [NREG_MAX-1:0] onehot(input int unsigned idx);
        return {{(NREG_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans from ptr+1 upward with wrap-around and returns the first requester
// that is asserted and not masked. Used both from IDLE and, in back-to-back
// builds, from LOAD with the current winner masked out.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] mask,
    output logic            found,
    output logic [PW-1:0]   winner
);

    logic [NREQ-1:0] cand;

    assign cand = req & ~mask;

    // First candidate after the pointer wins; the pointer itself is checked last.
    always_comb begin
        int idx;
        // NOTE: every output gets a value before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && cand[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Sequencer for transfers between register_oe instances sharing one
// tristate bus. Each transfer takes a DRIVE (bus settle) cycle followed by
// a LOAD cycle; all outputs are decoded from registered state only.
// Optional macro REG_BUS_B2B_EN: LOAD may hand the bus straight to the next
// requester, skipping IDLE.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NREQ   = NREQ_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int REG_AW = $clog2(NREG)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*REG_AW-1:0] req_src,
    input  logic [NREQ*REG_AW-1:0] req_dst,
    output logic [NREQ-1:0]        gnt,
    output logic [NREG-1:0]        reg_enable,
    output logic [NREG-1:0]        reg_load,
    output logic                   busy
);

    localparam int PW = $clog2(NREQ);

    state_t            state, state_nxt;
    logic [REG_AW-1:0] src_q, src_nxt;
    logic [REG_AW-1:0] dst_q, dst_nxt;
    logic [PW-1:0]     win_q, win_nxt;
    logic [PW-1:0]     ptr_q, ptr_nxt;

    logic [PW-1:0]     arb_ptr;
    logic [NREQ-1:0]   arb_mask;
    logic              arb_found;
    logic [PW-1:0]     arb_win;
    logic [REG_AW-1:0] arb_src;
    logic [REG_AW-1:0] arb_dst;

    logic [NREG_MAX-1:0] en_wide;
    logic [NREG_MAX-1:0] ld_wide;
    logic                unused_dec;

`ifdef REG_BUS_B2B_EN
    // From LOAD, search after the current winner and skip it, so a different
    // requester takes the next slot without an IDLE gap.
    assign arb_ptr  = (state == LOAD) ? win_q : ptr_q;
    assign arb_mask = (state == LOAD) ? (NREQ'(1) << win_q) : '0;
`else
    assign arb_ptr  = ptr_q;
    assign arb_mask = '0;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req    (req),
        .ptr    (arb_ptr),
        .mask   (arb_mask),
        .found  (arb_found),
        .winner (arb_win)
    );

    assign arb_src = req_src[int'(arb_win)*REG_AW +: REG_AW];
    assign arb_dst = req_dst[int'(arb_win)*REG_AW +: REG_AW];

    // Decode from the latched indices; out-of-range indices decode to zero.
    assign en_wide    = onehot(32'(src_q));
    assign ld_wide    = onehot(32'(dst_q));
    assign unused_dec = ^{en_wide, ld_wide};

    // State, latched transfer and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            win_q <= '0;
            ptr_q <= PW'(NREQ - 1);
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge
            // values, independent of statement order.
            state <= state_nxt;
            src_q <= src_nxt;
            dst_q <= dst_nxt;
            win_q <= win_nxt;
            ptr_q <= ptr_nxt;
        end
    end

    // Next-state sequencing and Moore output decode.
    always_comb begin
        state_nxt  = state;
        src_nxt    = src_q;
        dst_nxt    = dst_q;
        win_nxt    = win_q;
        ptr_nxt    = ptr_q;
        gnt        = '0;
        reg_enable = '0;
        reg_load   = '0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    src_nxt   = arb_src;
                    dst_nxt   = arb_dst;
                    win_nxt   = arb_win;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                reg_enable = en_wide[NREG-1:0];
                state_nxt  = LOAD;
            end
            LOAD: begin
                reg_enable   = en_wide[NREG-1:0];
                reg_load     = ld_wide[NREG-1:0];
                gnt[win_q]   = 1'b1;
                ptr_nxt      = win_q;
                state_nxt    = IDLE;
`ifdef REG_BUS_B2B_EN
                if (arb_found) begin
                    src_nxt   = arb_src;
                    dst_nxt   = arb_dst;
                    win_nxt   = arb_win;
                    state_nxt = DRIVE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter. Stimulus pushes the expected
// grant (gnt, source enable, destination load, cycle) into a scoreboard; a
// monitor on the falling edge pops and compares whenever gnt pulses. A small
// behavioural register bank on the bus confirms the data actually moves.
module tb_reg_bus_arbiter;

    localparam int NREQ   = 4;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;
`ifdef REG_BUS_B2B_EN
    localparam int P = 2;
`else
    localparam int P = 3;
`endif

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*REG_AW-1:0] req_src;
    logic [NREQ*REG_AW-1:0] req_dst;
    logic [NREQ-1:0]        gnt;
    logic [NREG-1:0]        reg_enable;
    logic [NREG-1:0]        reg_load;
    logic                   busy;

    reg_bus_arbiter #(
        .NREQ   (NREQ),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .gnt        (gnt),
        .reg_enable (reg_enable),
        .reg_load   (reg_load),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural register bank on the shared bus.
    logic [7:0] regbank [NREG];
    logic       bank_init;
    logic [7:0] bus;

    always_comb begin
        bus = '0;
        for (int i = 0; i < NREG; i++)
            if (reg_enable[i]) bus = regbank[i];
    end

    always @(posedge clock) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_init)        regbank[i] <= 8'h10 + 8'(i);
            else if (reg_load[i]) regbank[i] <= bus;
        end
    end

    // Scoreboard of expected grants.
    typedef struct {
        logic [NREQ-1:0] g;
        logic [NREG-1:0] en;
        logic [NREG-1:0] ld;
        int              at;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [NREQ-1:0] g, input logic [NREG-1:0] en,
                        input logic [NREG-1:0] ld, input int at);
        exp_t e;
        e.g  = g;
        e.en = en;
        e.ld = ld;
        e.at = at;
        sb.push_back(e);
    endtask

    // Monitor: one-hot invariant every cycle; full transfer check on each gnt.
    logic [NREG-1:0] prev_en = '0;
    logic [NREG-1:0] prev_ld = '0;

    always @(negedge clock) begin
        exp_t e;
        check("enable_popcount", 32'($countones(reg_enable) <= 1), 32'd1);
        check("load_popcount",   32'($countones(reg_load) <= 1),   32'd1);
        if (gnt != '0) begin
            if (sb.size() == 0) begin
                check("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                e = sb.pop_front();
                check("gnt",          32'(gnt),        32'(e.g));
                check("load_enable",  32'(reg_enable), 32'(e.en));
                check("load_load",    32'(reg_load),   32'(e.ld));
                check("gnt_cycle",    32'(cyc),        32'(e.at));
                check("drive_enable", 32'(prev_en),    32'(e.en));
                check("drive_load",   32'(prev_ld),    32'd0);
                check("load_busy",    32'(busy),       32'd1);
            end
        end
        prev_en = reg_enable;
        prev_ld = reg_load;
    end

    task automatic set_req(input int i, input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] d);
        req_src[i*REG_AW +: REG_AW] = s;
        req_dst[i*REG_AW +: REG_AW] = d;
        req[i] = 1'b1;
    endtask

    // Advance n falling edges; optionally drop each req once its gnt is seen.
    task automatic run(input int n, input bit drop);
        repeat (n) begin
            @(negedge clock);
            if (drop) req = req & ~gnt;
        end
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset     = 1'b1;
        bank_init = 1'b1;
        req       = '0;
        @(negedge clock);
        reset     = 1'b0;
        bank_init = 1'b0;
    endtask

    initial begin
        int c;
        reset     = 1'b1;
        bank_init = 1'b1;
        req       = '0;
        req_src   = '0;
        req_dst   = '0;
        repeat (2) @(negedge clock);
        check("rst_gnt",    32'(gnt),        32'd0);
        check("rst_enable", 32'(reg_enable), 32'd0);
        check("rst_load",   32'(reg_load),   32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        reset     = 1'b0;
        bank_init = 1'b0;

        // Single transfer: requester 2, reg5 -> reg1.
        c = cyc;
        set_req(2, 3'd5, 3'd1);
        push(4'b0100, 8'b0010_0000, 8'b0000_0010, c + 2);
        run(3, 1'b1);
        check("single_idle_busy", 32'(busy),       32'd0);
        check("single_reg1",      32'(regbank[1]), 32'h15);

        // Round-robin with all four held: order 0,1,2,3,0.
        reset_dut();
        c = cyc;
        set_req(0, 3'd0, 3'd4);
        set_req(1, 3'd1, 3'd5);
        set_req(2, 3'd2, 3'd6);
        set_req(3, 3'd3, 3'd7);
        push(4'b0001, 8'b0000_0001, 8'b0001_0000, c + 2);
        push(4'b0010, 8'b0000_0010, 8'b0010_0000, c + 2 + P);
        push(4'b0100, 8'b0000_0100, 8'b0100_0000, c + 2 + 2*P);
        push(4'b1000, 8'b0000_1000, 8'b1000_0000, c + 2 + 3*P);
        push(4'b0001, 8'b0000_0001, 8'b0001_0000, c + 2 + 4*P);
        run(2 + 4*P, 1'b0);
        req = '0;
        run(2, 1'b0);
        check("rr_idle_busy", 32'(busy), 32'd0);

        // Withdrawal during DRIVE: requester 1, reg3 -> reg6 still completes.
        c = cyc;
        set_req(1, 3'd3, 3'd6);
        push(4'b0010, 8'b0000_1000, 8'b0100_0000, c + 2);
        run(1, 1'b0);
        req[1] = 1'b0;
        run(2, 1'b1);
        check("wd_busy_after",  32'(busy),       32'd0);
        check("wd_reg6",        32'(regbank[6]), 32'h13);
        run(1, 1'b1);
        check("wd_idle_stays",  32'(busy),       32'd0);

        // Reset during DRIVE aborts the transfer without a grant.
        set_req(3, 3'd4, 3'd5);
        run(1, 1'b0);
        check("mid_drive_busy",   32'(busy),       32'd1);
        check("mid_drive_enable", 32'(reg_enable), 32'h10);
        reset = 1'b1;
        req   = '0;
        #1;
        check("mid_rst_gnt",    32'(gnt),        32'd0);
        check("mid_rst_enable", 32'(reg_enable), 32'd0);
        check("mid_rst_load",   32'(reg_load),   32'd0);
        check("mid_rst_busy",   32'(busy),       32'd0);
        @(negedge clock);
        reset = 1'b0;
        c = cyc;
        set_req(0, 3'd1, 3'd2);
        set_req(3, 3'd4, 3'd5);
        push(4'b0001, 8'b0000_0010, 8'b0000_0100, c + 2);
        push(4'b1000, 8'b0001_0000, 8'b0010_0000, c + 2 + P);
        run(3 + P, 1'b1);

        // src == dst == 7: reg7 reloads itself.
        reset_dut();
        c = cyc;
        set_req(2, 3'd7, 3'd7);
        push(4'b0100, 8'b1000_0000, 8'b1000_0000, c + 2);
        run(3, 1'b1);
        check("same_reg7", 32'(regbank[7]), 32'h17);

        // Two requesters: 0 then 1, P cycles apart.
        c = cyc;
        set_req(0, 3'd0, 3'd3);
        set_req(1, 3'd1, 3'd2);
        push(4'b0001, 8'b0000_0001, 8'b0000_1000, c + 2);
        push(4'b0010, 8'b0000_0010, 8'b0000_0100, c + 2 + P);
        run(3 + P, 1'b1);
        check("pair_idle_busy", 32'(busy), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
